// File: rtl/sys_defs.sv
// Shared definitions for the retirement map table slice: lane count,
// register-file sizes, tag types and the per-lane retire packet.
// The lane count comes from the N macro and defaults to 2 when it is not
// defined on the command line.
`ifndef N
`define N 2
`endif

package sys_defs;

    localparam int N_LANES     = `N;
    localparam int ARCH_REG_SZ = 32;
    localparam int PHYS_REG_SZ = 64;
    localparam int ARCH_TAG_W  = $clog2(ARCH_REG_SZ);
    localparam int PHYS_TAG_W  = $clog2(PHYS_REG_SZ);

    typedef logic [ARCH_TAG_W-1:0] ARCH_TAG;
    typedef logic [PHYS_TAG_W-1:0] PHYS_TAG;

    // One retiring instruction as seen by the map table.
    typedef struct packed {
        logic    valid;
        ARCH_TAG arch;
        PHYS_TAG new_tag;
    } RETIRE_PACKET;

endpackage

// File: rtl/retire_bypass.sv
// Combinational same-cycle bypass for the retirement map table.
// For every lane it works out the tag being displaced (taking older lanes of
// the same cycle into account) and whether the lane is the youngest active
// writer of its arch register, which decides who updates the map.
module retire_bypass
    import sys_defs::*;
(
    input  RETIRE_PACKET [N_LANES-1:0]                  pkt_i,
    input  logic [ARCH_REG_SZ-1:0][PHYS_TAG_W-1:0]      map_i,
    output logic [N_LANES-1:0]                          active_o,
    output logic [N_LANES-1:0]                          write_en_o,
    output logic [N_LANES-1:0][PHYS_TAG_W-1:0]          old_tag_o
);

    genvar gi;
    generate
        for (gi = 0; gi < N_LANES; gi++) begin : g_lane
            PHYS_TAG old_tag_c;
            logic    write_en_c;

            // Arch register 0 has no mapping, so such lanes do nothing.
            assign active_o[gi] = pkt_i[gi].valid && (pkt_i[gi].arch != '0);

            // Displaced tag: the youngest older same-arch lane wins over the map.
            always_comb begin
                old_tag_c = map_i[pkt_i[gi].arch];
                for (int j = 0; j < gi; j++) begin
                    if (active_o[j] && (pkt_i[j].arch == pkt_i[gi].arch)) begin
                        old_tag_c = pkt_i[j].new_tag;
                    end
                end
            end

            // Only the youngest active writer of an arch register updates the map.
            always_comb begin
                write_en_c = active_o[gi];
                for (int j = gi + 1; j < N_LANES; j++) begin
                    if (active_o[j] && (pkt_i[j].arch == pkt_i[gi].arch)) begin
                        write_en_c = 1'b0;
                    end
                end
            end

            assign old_tag_o[gi]  = old_tag_c;
            assign write_en_o[gi] = write_en_c;
        end
    endgenerate

endmodule

// File: rtl/retire_map_table.sv
// Committed (retirement) arch->phys register map. Retiring lanes write their
// new physical tag into the map and hand the displaced tag back to the
// freelist one cycle later, lane positions preserved.
// Optional build macro RETIRE_MAP_CHECK_EN adds a committed-ownership vector
// that raises a sticky MapError when a tag is committed twice or is zero.
module retire_map_table
    import sys_defs::*;
(
    input  logic                                    clock,
    input  logic                                    reset_n,
    input  logic [N_LANES-1:0]                      RetireValid,
    input  logic [N_LANES-1:0][ARCH_TAG_W-1:0]      RetireArch,
    input  logic [N_LANES-1:0][PHYS_TAG_W-1:0]      RetireNewTag,
    output logic [N_LANES-1:0]                      FreeEN,
    output logic [N_LANES-1:0][PHYS_TAG_W-1:0]      FreeReg,
    output logic [ARCH_REG_SZ-1:0][PHYS_TAG_W-1:0]  ArchMap,
    output logic                                    MapError
);

    RETIRE_PACKET [N_LANES-1:0]                 pkt;
    logic [N_LANES-1:0]                         active;
    logic [N_LANES-1:0]                         write_en;
    logic [N_LANES-1:0][PHYS_TAG_W-1:0]         old_tag;

    logic [ARCH_REG_SZ-1:0][PHYS_TAG_W-1:0]     map_q, map_d;
    logic [N_LANES-1:0]                         free_en_q, free_en_d;
    logic [N_LANES-1:0][PHYS_TAG_W-1:0]         free_reg_q, free_reg_d;

    genvar gi;
    generate
        for (gi = 0; gi < N_LANES; gi++) begin : g_lane
            assign pkt[gi].valid   = RetireValid[gi];
            assign pkt[gi].arch    = RetireArch[gi];
            assign pkt[gi].new_tag = RetireNewTag[gi];

            // A displaced tag of zero is never returned to the freelist.
            assign free_en_d[gi]  = active[gi] && (old_tag[gi] != '0);
            assign free_reg_d[gi] = active[gi] ? old_tag[gi] : '0;
        end
    endgenerate

    retire_bypass u_bypass (
        .pkt_i      (pkt),
        .map_i      (map_q),
        .active_o   (active),
        .write_en_o (write_en),
        .old_tag_o  (old_tag)
    );

    // Next map: each youngest writer drops its new tag into its arch slot.
    always_comb begin
        map_d = map_q;
        for (int i = 0; i < N_LANES; i++) begin
            if (write_en[i]) begin
                map_d[pkt[i].arch] = pkt[i].new_tag;
            end
        end
    end

    // Map and free-port registers; reset restores the identity map.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < ARCH_REG_SZ; i++) begin
                map_q[i] <= PHYS_TAG_W'(i);
            end
            free_en_q  <= '0;
            free_reg_q <= '0;
        end else begin
            map_q      <= map_d;
            free_en_q  <= free_en_d;
            free_reg_q <= free_reg_d;
        end
    end

    assign ArchMap = map_q;
    assign FreeEN  = free_en_q;
    assign FreeReg = free_reg_q;

`ifdef RETIRE_MAP_CHECK_EN
    logic [PHYS_REG_SZ-1:0] own_q, own_d;
    logic                   err_q, err_d;

    // Walk lanes oldest first so tags freed by older lanes are no longer owned.
    always_comb begin
        own_d = own_q;
        err_d = err_q;
        for (int i = 0; i < N_LANES; i++) begin
            if (active[i]) begin
                if (own_d[pkt[i].new_tag] || (pkt[i].new_tag == '0)) begin
                    err_d = 1'b1;
                end
                if (free_en_d[i]) begin
                    own_d[old_tag[i]] = 1'b0;
                end
                own_d[pkt[i].new_tag] = 1'b1;
            end
        end
    end

    // Ownership vector and sticky error; identity-mapped tags start owned.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < PHYS_REG_SZ; i++) begin
                own_q[i] <= (i < ARCH_REG_SZ);
            end
            err_q <= 1'b0;
        end else begin
            own_q <= own_d;
            err_q <= err_d;
        end
    end

    // Flag the first cycle an ownership violation is committed.
    always @(posedge clock) begin
        assert (!(reset_n && err_d && !err_q))
            else $error("retire_map_table: committed tag ownership violated");
    end

    assign MapError = err_q;
`else
    assign MapError = 1'b0;
`endif

endmodule

// File: doc/retire_map_table.md
Name: retire_map_table

Overview:
- Architectural (retirement) register map table.
- Each retiring instruction writes its new physical tag into the committed arch→phys map.
- The physical tag it displaces is returned to the freelist through the freelist's RetireEN/RetireReg return port.
- Sits between ROB retire and freelist. Its ArchMap output is the committed map used to restore the speculative map table on mispredict recovery.

Parameters:
N, `N, retire/free lanes per cycle; lane 0 oldest
ARCH_REGS, 32, architectural registers (x0 included)
PHYS_REGS, 64, physical registers; PHYS_TAG width = $clog2(PHYS_REGS)

Ports:
clock  in  1  clock
reset_n  in  1  synchronous, active-low reset
RetireValid  in  N  lane retires an instruction this cycle
RetireArch  in  N x ARCH_TAG  destination arch reg; 0 = no destination
RetireNewTag  in  N x PHYS_TAG  physical tag allocated at dispatch for that destination
FreeEN  out  N  to freelist RetireEN
FreeReg  out  N x PHYS_TAG  to freelist RetireReg
ArchMap  out  ARCH_REGS x PHYS_TAG  committed map, registered
MapError  out  1  sticky protocol error; constant 0 unless RETIRE_MAP_CHECK_EN

Behaviour:
- Reset (reset_n=0 at posedge):
  - map[i] = i for all i.
  - FreeEN = 0, FreeReg = 0, MapError = 0.
  - Reset mid-operation discards any in-flight retire; the freelist is reset with it.
- Freelist contract: its initial contents are tags ARCH_REGS..PHYS_REGS-1. Tag 0 is never granted and never freed by this block.
- Lane active = RetireValid[i] && RetireArch[i] != 0. Inactive lanes:
  - no map update;
  - FreeEN[i] = 0 next cycle.
- Old tag per active lane i:
  - If older active lanes j<i in the same cycle have the same arch reg, OldTag[i] = RetireNewTag of the youngest such j.
  - Otherwise OldTag[i] = map[RetireArch[i]] (pre-edge value).
- Map update at posedge: for each arch reg, the youngest active lane writing it wins.
- Free output latency is 1 cycle, registered:
  - FreeEN[i] <= active[i];
  - FreeReg[i] <= active ? OldTag[i] : 0.
  - Lane positions are preserved (lane i frees on FreeEN[i]).
- ArchMap reflects the map register directly; an update is visible the cycle after retire.
- Zero-tag guard: an active lane with OldTag == 0 suppresses its free (FreeEN[i] = 0). This cannot occur in legal operation.
- No backpressure: the freelist always accepts returns, because returns never exceed prior grants. RetireValid is not required to be lane-compacted.
- RetireNewTag == 0 on an active lane is illegal (undefined map contents, but never freed later, per the zero guard).

Optional Feature:
RETIRE_MAP_CHECK_EN
- Defined:
  - Keep a PHYS_REGS-bit committed-ownership vector; reset sets bits 0..ARCH_REGS-1.
  - Per active lane, MapError is set (sticky until reset) if RetireNewTag is already owned (ignoring tags freed earlier in the same cycle), or if it is 0.
  - At posedge, clear the bit for each freed tag and set the bit for each new tag.
  - Add an $error on the rising MapError.
- Undefined: no vector, MapError tied 0, no assertions.

Decomposition:
- sys_defs package holds:
  - ARCH_TAG typedef (logic [$clog2(ARCH_REGS)-1:0]) and existing PHYS_TAG;
  - ARCH_REG_SZ / PHYS_REG_SZ constants;
  - RETIRE_PACKET struct {valid, arch, new_tag}.
- One sub-module: retire_bypass (combinational) computes per-lane OldTag and the youngest-writer enables. Sequential state stays in the top.

Test Plan:
- Reset, then lane0 retire arch 5 new tag 40 → next cycle FreeEN[0]=1, FreeReg[0]=5, ArchMap[5]=40; a second retire of arch 5 tag 41 frees 40.
- Same cycle (N≥2): lane0 arch 3 tag 33, lane1 arch 3 tag 34 → FreeReg[0]=3, FreeReg[1]=33, ArchMap[3]=34.
- Lane0 arch 0 tag 50 valid, lane1 invalid → FreeEN=0, ArchMap unchanged.
- Closed loop with freelist:
  - drain all 32 free tags by retiring through arch 1..31 cyclically;
  - every returned tag is re-granted exactly once;
  - never tag 0, no duplicates among live tags.
- Reset asserted the cycle after a retire of arch 7 tag 45 → FreeEN=0, ArchMap[7]=7 after reset.
- RETIRE_MAP_CHECK_EN: retire arch 2 tag 40 then arch 4 tag 40 → MapError=1 the next cycle and stays 1; without the macro MapError stays 0.
